// File: rtl/bus_timer_pkg.sv
// Shared bus field layout plus the timer register map and bit positions;
// firmware headers are generated from the constants below.
package bus_timer_pkg;

    localparam int BUS_IN_WIDTH  = 72;
    localparam int BUS_OUT_WIDTH = 34;

    typedef struct packed {
        logic        reset_b;
        logic        clk;
        logic        wr_req;
        logic        rd_req;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
    } bus_in_t;

    typedef struct packed {
        logic        wr_ack;
        logic        rd_ack;
        logic [31:0] rd_data;
    } bus_out_t;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_RELOAD = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_PERIODIC_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT    = 2;
    localparam int CTRL_PRESCALE_LSB  = 8;
    localparam int PRESCALE_W         = 16;

    localparam int STATUS_EXPIRED_BIT = 0;
    localparam int STATUS_EN_BIT      = 1;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: pcnt counts up while enabled and emits a tick
// on reaching the PRESCALE value, then wraps to 0.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clear || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with a 16-byte register window,
// single-cycle bus acknowledge and a registered level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BUS_ADDR = 32'h0200_0020
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    output logic                     irq
);

    bus_in_t  bin;
    bus_out_t bout;

    logic        sel, rd_hit, wr_hit;
    logic [3:0]  ofs;
    logic        wr_ctrl, wr_count, wr_reload, wr_status;

    logic        en, periodic, irq_en, expired;
    logic [15:0] prescale;
    logic [31:0] count, reload;

    logic        en_next, periodic_next, irq_en_next, expired_next;
    logic [15:0] prescale_next;
    logic [31:0] count_next, reload_next;

    logic        tick, expiry;
    logic [31:0] rd_mux;
    logic        rd_ack_q, wr_ack_q;
    logic [31:0] rd_data_q;
    logic        unused_bus_fields;

    assign bin = bus_in;
    // The clock/reset fields of the bus and the byte lane bits play no part here.
    assign unused_bus_fields = ^{bin.clk, bin.reset_b, bin.addr[1:0]};

    assign sel    = (bin.addr[31:4] == BUS_ADDR[31:4]);
    assign ofs    = {bin.addr[3:2], 2'b00};
    assign rd_hit = sel && bin.rd_req;
    assign wr_hit = sel && bin.wr_req;

    assign wr_ctrl   = wr_hit && (ofs == OFS_CTRL);
    assign wr_count  = wr_hit && (ofs == OFS_COUNT);
    assign wr_reload = wr_hit && (ofs == OFS_RELOAD);
    assign wr_status = wr_hit && (ofs == OFS_STATUS);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (wr_ctrl || wr_count),
        .prescale (prescale),
        .tick     (tick)
    );

    assign expiry = tick && (count == 32'd0);

    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_CTRL: begin
                rd_mux[CTRL_EN_BIT]                       = en;
                rd_mux[CTRL_PERIODIC_BIT]                 = periodic;
                rd_mux[CTRL_IRQ_EN_BIT]                   = irq_en;
                rd_mux[CTRL_PRESCALE_LSB +: PRESCALE_W]   = prescale;
            end
            OFS_COUNT:  rd_mux = count;
            OFS_RELOAD: rd_mux = reload;
            OFS_STATUS: begin
                rd_mux[STATUS_EXPIRED_BIT] = expired;
                rd_mux[STATUS_EN_BIT]      = en;
            end
            default: rd_mux = '0;
        endcase
    end

    // Counting updates first; a bus write to the same register then overrides it.
    always_comb begin
        en_next       = en && !(expiry && !periodic);
        periodic_next = periodic;
        irq_en_next   = irq_en;
        prescale_next = prescale;
        count_next    = count;
        reload_next   = reload;
        expired_next  = expired;

        if (tick) begin
            if (count == 32'd0) count_next = periodic ? reload : 32'd0;
            else                count_next = count - 32'd1;
        end

        if (wr_ctrl) begin
            if (bin.be[0]) begin
                en_next       = bin.wdata[CTRL_EN_BIT];
                periodic_next = bin.wdata[CTRL_PERIODIC_BIT];
                irq_en_next   = bin.wdata[CTRL_IRQ_EN_BIT];
            end
            if (bin.be[1]) prescale_next[7:0]  = bin.wdata[CTRL_PRESCALE_LSB +: 8];
            if (bin.be[2]) prescale_next[15:8] = bin.wdata[CTRL_PRESCALE_LSB + 8 +: 8];
        end
        if (wr_count)  count_next  = byte_merge(count, bin.wdata, bin.be);
        if (wr_reload) reload_next = byte_merge(reload, bin.wdata, bin.be);
        if (wr_status && bin.be[0] && bin.wdata[STATUS_EXPIRED_BIT]) expired_next = 1'b0;
        if (expiry) expired_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en        <= 1'b0;
            periodic  <= 1'b0;
            irq_en    <= 1'b0;
            prescale  <= '0;
            count     <= '0;
            reload    <= '0;
            expired   <= 1'b0;
            irq       <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            en        <= en_next;
            periodic  <= periodic_next;
            irq_en    <= irq_en_next;
            prescale  <= prescale_next;
            count     <= count_next;
            reload    <= reload_next;
            expired   <= expired_next;
            irq       <= expired && irq_en;
            rd_ack_q  <= rd_hit;
            wr_ack_q  <= wr_hit;
            rd_data_q <= rd_hit ? rd_mux : 32'd0;
        end
    end

    assign bout.rd_data = rd_data_q;
    assign bout.rd_ack  = rd_ack_q;
    assign bout.wr_ack  = wr_ack_q;
    assign bus_out      = bout;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: a cycle-level reference model predicts every
// bus response and the interrupt level; a monitor compares them as they appear.
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0020;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;
    logic                     irq;

    bus_timer #(.BUS_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        is_rd;
        bit [31:0] data;
        int        due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_on = 0;
    bit   exp_irq_now = 0;
    bit   irq_obs = 0;

    // reference state
    bit          m_en, m_per, m_ien, m_exp, m_irq;
    int unsigned m_pre, m_pcnt;
    bit [31:0]   m_count, m_reload;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit [31:0] lane_merge(input bit [31:0] old_v, input bit [31:0] wd, input bit [3:0] be);
        bit [31:0] mask;
        mask = 0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_v & ~mask) | (wd & mask);
    endfunction

    function automatic bit [31:0] model_read(input int w);
        case (w)
            0: return (m_pre << 8) | (32'(m_ien) << 2) | (32'(m_per) << 1) | 32'(m_en);
            1: return m_count;
            2: return m_reload;
            default: return (32'(m_en) << 1) | 32'(m_exp);
        endcase
    endfunction

    task automatic model_step(input bit rd, input bit wr, input bit [31:0] addr,
                              input bit [31:0] wd, input bit [3:0] be, input bit rst);
        bit          hit, tick, expiry;
        int          w;
        bit          n_en, n_per, n_ien, n_exp;
        int unsigned n_pre, n_pcnt;
        bit [31:0]   n_count, n_reload;
        if (rst) begin
            {m_en, m_per, m_ien, m_exp, m_irq} = 0;
            m_pre = 0; m_pcnt = 0; m_count = 0; m_reload = 0;
            return;
        end
        hit = ((addr >> 4) == (BASE >> 4));
        w   = int'((addr >> 2) & 3);
        if (hit && rd) sb.push_back('{1'b1, model_read(w), cyc + 1});
        if (hit && wr) sb.push_back('{1'b0, 32'd0, cyc + 1});

        tick   = m_en && (m_pcnt == m_pre);
        expiry = tick && (m_count == 0);
        n_count = m_count;
        if (tick) n_count = expiry ? (m_per ? m_reload : 32'd0) : m_count - 1;
        n_pcnt = m_en ? (tick ? 0 : (m_pcnt + 1) % 65536) : m_pcnt;
        n_en   = (expiry && !m_per) ? 1'b0 : m_en;
        n_per = m_per; n_ien = m_ien; n_pre = m_pre;
        n_exp = m_exp; n_reload = m_reload;

        if (hit && wr) begin
            case (w)
                0: begin
                    if (be[0]) begin n_en = wd[0]; n_per = wd[1]; n_ien = wd[2]; end
                    if (be[1]) n_pre = (n_pre & 32'hFF00) | ((wd >> 8) & 32'hFF);
                    if (be[2]) n_pre = (n_pre & 32'h00FF) | (((wd >> 16) & 32'hFF) << 8);
                    n_pcnt = 0;
                end
                1: begin n_count = lane_merge(m_count, wd, be); n_pcnt = 0; end
                2: n_reload = lane_merge(m_reload, wd, be);
                default: if (be[0] && wd[0]) n_exp = 0;
            endcase
        end
        if (expiry) n_exp = 1;

        m_irq = m_exp && m_ien;
        m_en = n_en; m_per = n_per; m_ien = n_ien; m_pre = n_pre; m_pcnt = n_pcnt;
        m_count = n_count; m_reload = n_reload; m_exp = n_exp;
    endtask

    task automatic cycle(input bit rd, input bit wr, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [3:0] be, input bit rst);
        bus_in_t bi;
        @(posedge clk);
        #1;
        irq_obs     = irq;
        exp_irq_now = m_irq;
        bi.reset_b = 1'($urandom);
        bi.clk     = 1'($urandom);
        bi.wr_req  = wr;
        bi.rd_req  = rd;
        bi.be      = be;
        bi.wdata   = wd;
        bi.addr    = addr;
        bus_in = bi;
        reset  = rst;
        model_step(rd, wr, addr, wd, be, rst);
    endtask

    task automatic idle();
        cycle(0, 0, 32'd0, 32'd0, 4'd0, 0);
    endtask

    task automatic rd(input bit [31:0] a);
        cycle(1, 0, a, 32'd0, 4'd0, 0);
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d, input bit [3:0] be);
        cycle(0, 1, a, d, be, 0);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        bus_out_t o;
        exp_t     e;
        if (mon_on) begin
            o = bus_out_t'(bus_out);
            n_cmp++;
            if (irq !== exp_irq_now) begin
                n_err++;
                $display("FAIL irq: got %b expected %b (cycle %0d)", irq, exp_irq_now, cyc);
            end
            if (o.rd_ack || o.wr_ack) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_ack: got bus_out %h expected no response (cycle %0d)", bus_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (o.rd_ack !== e.is_rd || o.wr_ack !== !e.is_rd || e.due != cyc ||
                        o.rd_data !== e.data) begin
                        n_err++;
                        $display("FAIL response: got rd_ack=%b wr_ack=%b data=%h at cycle %0d expected rd_ack=%b data=%h at cycle %0d",
                                 o.rd_ack, o.wr_ack, o.rd_data, cyc, e.is_rd, e.data, e.due);
                    end
                end
            end else begin
                n_cmp++;
                if (bus_out !== '0 || (sb.size() != 0 && sb[0].due <= cyc)) begin
                    n_err++;
                    $display("FAIL idle_bus: got bus_out %h expected 0 with ack due (pending %0d, cycle %0d)",
                             bus_out, sb.size(), cyc);
                end
            end
        end
    end

    initial begin
        int first;
        reset  = 1'b1;
        bus_in = '0;

        // reset values
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, BASE, 0, 4'hF, 1);
        mon_on = 1;
        for (int i = 0; i < 4; i++) rd(BASE + 32'(4 * i));
        idle();

        // byte enables and out-of-window access
        wr(BASE + 8, 32'hAABBCCDD, 4'b0101);
        rd(BASE + 8);
        wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'h10);
        rd(BASE - 4);
        idle();

        // one-shot: COUNT=3, PRESCALE=1 -> expiry 8 cycles after the CTRL write
        wr(BASE + 4, 32'd3, 4'hF);
        wr(BASE + 0, 32'h0000_0105, 4'hF);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (irq_obs && first == 0) first = k;
        end
        check("oneshot_irq_cycle", first, 10);
        rd(BASE + 32'hC);
        rd(BASE + 4);
        wr(BASE + 32'hC, 32'h1, 4'h1);
        rd(BASE + 32'hC);

        // periodic: RELOAD=4, PRESCALE=0 -> expiries every 5 cycles
        wr(BASE + 8, 32'd4, 4'hF);
        wr(BASE + 4, 32'd4, 4'hF);
        wr(BASE + 0, 32'h7, 4'hF);
        for (int k = 0; k < 6; k++) idle();
        wr(BASE + 32'hC, 32'h1, 4'h1);
        idle();
        idle();
        wr(BASE + 32'hC, 32'h1, 4'h1);
        rd(BASE + 32'hC);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            idle();
            if (irq_obs) first++;
        end
        check("periodic_irq_held", first, 12);

        // COUNT write colliding with a tick
        wr(BASE + 4, 32'd100, 4'hF);
        rd(BASE + 4);
        rd(BASE + 4);
        wr(BASE + 0, 32'h0, 4'hF);
        rd(BASE + 4);
        idle();

        // reset in the ack cycle of a read, plus a request alongside reset
        wr(BASE + 4, 32'd55, 4'hF);
        rd(BASE + 4);
        cycle(1, 0, BASE + 4, 0, 4'hF, 1);
        idle();
        check("reset_drops_ack", int'(bus_out != '0), 0);
        for (int i = 0; i < 4; i++) rd(BASE + 32'(4 * i));
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int        r, w;
            bit [31:0] a, d;
            bit [3:0]  be;
            r  = int'($urandom_range(0, 99));
            w  = int'($urandom_range(0, 3));
            a  = BASE + 32'(4 * w);
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 + 32'(4 * w) : $urandom;
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (w)
                0: d = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7)) | ($urandom & 32'hFF00_00F8);
                1: d = 32'($urandom_range(0, 15));
                2: d = 32'($urandom_range(0, 10));
                default: d = $urandom;
            endcase
            if (r < 1)       cycle(0, 0, a, d, be, 1);
            else if (r < 30) rd(a);
            else if (r < 50) wr(a, d, be);
            else             idle();
        end

        for (int k = 0; k < 4; k++) idle();
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
